// File: rtl/pwm_pkg.sv
// Shared types for the PWM capture block.
// Measurement FSM states and the default counter width.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF
  } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Input synchroniser, polarity correction and edge detection.
// Both edges share one pipeline, so rise and fall latency match.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic INACT = ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync;
  logic s;
  logic s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= {SYNC_STAGES{INACT}};
      s_q  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      s_q  <= s;
    end
  end

  assign s     = sync[SYNC_STAGES-1] ^ INACT;
  assign rise  = s & ~s_q;
  assign fall  = ~s & s_q;
  assign level = s_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an incoming PWM waveform.
// The first partial period after reset or stall is discarded.
import pwm_pkg::*;

module pwm_capture #(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic             level,
  output logic             valid,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] per_cnt, per_n;
  logic [CNT_W-1:0] hi_cnt, hi_n;
  logic [CNT_W-1:0] ht_n, pd_n;
  logic             valid_n, stalled_n;
  logic             rise, fall, sat;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  assign sat = per_cnt == CNT_MAX;

  always_comb begin
    state_n   = state;
    per_n     = sat ? per_cnt : per_cnt + ONE;
    hi_n      = hi_cnt;
    ht_n      = high_time;
    pd_n      = period;
    valid_n   = 1'b0;
    stalled_n = stalled;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_n   = ON;
          per_n     = ONE;
          hi_n      = ONE;
          stalled_n = 1'b0;
        end
      end
      ON: begin
        if (fall) state_n = OFF;
        else      hi_n    = hi_cnt + ONE;
      end
      OFF: begin
        if (rise) begin
          state_n   = ON;
          valid_n   = 1'b1;
          ht_n      = hi_cnt;
          pd_n      = per_cnt;
          per_n     = ONE;
          hi_n      = ONE;
          stalled_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
    // a rise landing on the saturated cycle still measures
    if (sat && !rise) begin
      stalled_n = 1'b1;
      state_n   = IDLE;
      hi_n      = hi_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      valid     <= 1'b0;
      high_time <= '0;
      period    <= '0;
      stalled   <= 1'b0;
    end else begin
      state     <= state_n;
      per_cnt   <= per_n;
      hi_cnt    <= hi_n;
      valid     <= valid_n;
      high_time <= ht_n;
      period    <= pd_n;
      stalled   <= stalled_n;
    end
  end

endmodule
